// File: rtl/da_lut_pkg.sv
// Shared constants and state type for the distributed-arithmetic LUT loader.
package da_lut_pkg;

  localparam int NTAPS  = 64;
  localparam int GROUP  = 8;
  localparam int COEF_W = 16;
  localparam int LUT_W  = 19;
  localparam int ADDR_W = 11;
  localparam int SUM_W  = 32;

  localparam int NGROUP = NTAPS / GROUP;
  localparam int GRP_W  = $clog2(NGROUP);
  localparam int GSEL_W = $clog2(GROUP);
  localparam int CNT_W  = $clog2(NTAPS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    LOAD    = 2'd2,
    DONE    = 2'd3
  } state_t;

  function automatic logic [LUT_W-1:0] sext_coef(input logic [COEF_W-1:0] c);
    return {{(LUT_W-COEF_W){c[COEF_W-1]}}, c};
  endfunction

endpackage

// File: rtl/da_group_sum.sv
// Masked adder tree: sums the sign-extended taps of one DA group selected by mask_i.
module da_group_sum
  import da_lut_pkg::*;
(
  input  logic [GROUP-1:0][COEF_W-1:0] taps_i,
  input  logic [GROUP-1:0]             mask_i,
  output logic [LUT_W-1:0]             sum_o
);

  logic [GROUP-1:0][LUT_W-1:0]   term_s;
  logic [GROUP/2-1:0][LUT_W-1:0] lvl1_s;
  logic [GROUP/4-1:0][LUT_W-1:0] lvl2_s;

  // Gate each tap by its mask bit, then reduce pairwise in three levels
  always_comb begin
    for (int i = 0; i < GROUP; i++) begin
      if (mask_i[i]) begin
        term_s[i] = sext_coef(taps_i[i]);
      end else begin
        term_s[i] = {LUT_W{1'b0}};
      end
    end
    for (int i = 0; i < GROUP/2; i++) begin
      lvl1_s[i] = term_s[2*i] + term_s[2*i+1];
    end
    for (int i = 0; i < GROUP/4; i++) begin
      lvl2_s[i] = lvl1_s[2*i] + lvl1_s[2*i+1];
    end
    sum_o = lvl2_s[0] + lvl2_s[1];
  end

endmodule

// File: rtl/da_lut_loader.sv
// Collects 64 taps, then streams the 2048 DA partial-sum LUT words to fir_filter.
// Optional lut_sum checksum output enabled by DA_LUT_CHECKSUM_EN.
module da_lut_loader
  import da_lut_pkg::*;
(
  input  logic              clk_slow,
  input  logic              reset,
  input  logic              start,
  input  logic [COEF_W-1:0] coef_in,
  input  logic              coef_valid,
  output logic              coef_ready,
  output logic [LUT_W-1:0]  CIN,
  output logic [ADDR_W-1:0] CADDR,
  output logic              CLOAD,
  output logic              busy,
  output logic              done
`ifdef DA_LUT_CHECKSUM_EN
  ,
  output logic [SUM_W-1:0]  lut_sum
`endif
);

  localparam logic [CNT_W-1:0]  LAST_TAP  = CNT_W'(NTAPS - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  state_t                          state_q;
  logic [CNT_W-1:0]                cnt_q;
  logic [NTAPS-1:0][COEF_W-1:0]    tap_q;
  logic                            coef_ready_q;
  logic [LUT_W-1:0]                cin_q;
  logic [ADDR_W-1:0]               caddr_q;
  logic                            cload_q;
  logic                            busy_q;
  logic                            done_q;
`ifdef DA_LUT_CHECKSUM_EN
  logic [SUM_W-1:0]                lut_sum_q;
`endif

  logic [ADDR_W-1:0]               caddr_d;
  logic [GROUP-1:0][COEF_W-1:0]    grp_taps_s;
  logic [LUT_W-1:0]                grp_sum_s;

  // The LUT word is computed for the address about to be presented, so CIN and CADDR move together
  always_comb begin
    caddr_d = caddr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
    for (int b = 0; b < GROUP; b++) begin
      grp_taps_s[b] = tap_q[{caddr_d[ADDR_W-1 -: GRP_W], b[GSEL_W-1:0]}];
    end
  end

  da_group_sum u_group_sum (
    .taps_i (grp_taps_s),
    .mask_i (caddr_d[GROUP-1:0]),
    .sum_o  (grp_sum_s)
  );

  // Control FSM, tap bank and registered LUT-port outputs
  always_ff @(posedge clk_slow or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= {CNT_W{1'b0}};
      tap_q        <= {(NTAPS*COEF_W){1'b0}};
      coef_ready_q <= 1'b0;
      cin_q        <= {LUT_W{1'b0}};
      caddr_q      <= {ADDR_W{1'b0}};
      cload_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef DA_LUT_CHECKSUM_EN
      lut_sum_q    <= {SUM_W{1'b0}};
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q      <= COLLECT;
            cnt_q        <= {CNT_W{1'b0}};
            coef_ready_q <= 1'b1;
            busy_q       <= 1'b1;
          end
        end
        COLLECT: begin
          if (coef_valid && coef_ready_q) begin
            tap_q[cnt_q] <= coef_in;
            cnt_q        <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            if (cnt_q == LAST_TAP) begin
              state_q      <= LOAD;
              coef_ready_q <= 1'b0;
              cload_q      <= 1'b1;
              caddr_q      <= {ADDR_W{1'b0}};
              cin_q        <= {LUT_W{1'b0}};
`ifdef DA_LUT_CHECKSUM_EN
              lut_sum_q    <= {SUM_W{1'b0}};
`endif
            end
          end
        end
        LOAD: begin
`ifdef DA_LUT_CHECKSUM_EN
          lut_sum_q <= lut_sum_q + {{(SUM_W-LUT_W){cin_q[LUT_W-1]}}, cin_q};
`endif
          if (caddr_q == LAST_ADDR) begin
            state_q <= DONE;
            cload_q <= 1'b0;
            caddr_q <= {ADDR_W{1'b0}};
            cin_q   <= {LUT_W{1'b0}};
            done_q  <= 1'b1;
          end else begin
            caddr_q <= caddr_d;
            cin_q   <= grp_sum_s;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q      <= IDLE;
          coef_ready_q <= 1'b0;
          cload_q      <= 1'b0;
          caddr_q      <= {ADDR_W{1'b0}};
          cin_q        <= {LUT_W{1'b0}};
          busy_q       <= 1'b0;
          done_q       <= 1'b0;
        end
      endcase
    end
  end

  assign coef_ready = coef_ready_q;
  assign CIN        = cin_q;
  assign CADDR      = caddr_q;
  assign CLOAD      = cload_q;
  assign busy       = busy_q;
  assign done       = done_q;
`ifdef DA_LUT_CHECKSUM_EN
  assign lut_sum    = lut_sum_q;
`endif

endmodule
